// File: rtl/trust_event_pkg.sv
// Shared types and helpers for the trust event detector: FSM state encoding,
// vote popcount and elaboration-time parameter validation.
package trust_event_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SUSPECT = 2'd1,
        ST_CONFIRM = 2'd2,
        ST_HOLD    = 2'd3
    } state_t;

    localparam int MIN_SENSORS = 2;
    localparam int MAX_SENSORS = 32;

    // Callers zero-extend their channel vector to MAX_SENSORS bits.
    function automatic int unsigned popcount(input logic [MAX_SENSORS-1:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < MAX_SENSORS; i++) begin
            n = n + 32'(v[i]);
        end
        return n;
    endfunction

    function automatic bit params_ok(input int n_sensors, input int vote_k,
                                     input int persist, input int hold,
                                     input int stuck_limit, input int cnt_w);
        return (n_sensors >= MIN_SENSORS) && (n_sensors <= MAX_SENSORS) &&
               (vote_k >= 1) && (vote_k <= n_sensors) &&
               (persist >= 1) && (hold >= 1) &&
               (stuck_limit >= 1) && (cnt_w >= 1);
    endfunction

endpackage

// File: rtl/trust_event_detector_filter.sv
// One sensor channel: persistence debounce, uncorroborated-assertion (stuck)
// timer and the sticky fault bit that removes the channel from the vote.
module sensor_channel_filter
    import trust_event_pkg::*;
#(
    parameter int PERSIST     = 4,
    parameter int STUCK_LIMIT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic sensor,
    input  logic vote_met,
    input  logic fault_clr,
    output logic qualified,
    output logic fault
);
    localparam int PC_W = $clog2(PERSIST + 1);
    localparam int SC_W = $clog2(STUCK_LIMIT + 1);
    localparam logic [PC_W-1:0] PC_MAX = PC_W'(PERSIST);
    localparam logic [SC_W-1:0] SC_MAX = SC_W'(STUCK_LIMIT);

    logic [PC_W-1:0] r_pcnt;
    logic [SC_W-1:0] r_scnt;
    logic            r_fault;

    // NOTE: qualified is decoded from registers so the vote reflects this cycle's state without extra latency.
    assign qualified = (r_pcnt == PC_MAX) && !r_fault;
    assign fault     = r_fault;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pcnt  <= '0;
            r_scnt  <= '0;
            r_fault <= 1'b0;
        end else if (en) begin
            if (!sensor) begin
                r_pcnt <= '0;
            end else if (r_pcnt != PC_MAX) begin
                r_pcnt <= r_pcnt + PC_W'(1);
            end

            // Clear has priority over a coincident stuck-limit hit.
            if (fault_clr) begin
                r_scnt  <= '0;
                r_fault <= 1'b0;
            end else if (!sensor || vote_met) begin
                r_scnt <= '0;
            end else if (qualified) begin
                if (r_scnt == SC_MAX) begin
                    r_fault <= 1'b1;
                end else begin
                    r_scnt <= r_scnt + SC_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/trust_event_detector.sv
// K-of-N confirmed event detector: per-channel filters feed a vote that drives
// the IDLE/SUSPECT/CONFIRM/HOLD alarm FSM, trust map and event counter.
module trust_event_detector
    import trust_event_pkg::*;
#(
    parameter int N_SENSORS   = 3,
    parameter int VOTE_K      = 2,
    parameter int PERSIST     = 4,
    parameter int HOLD        = 8,
    parameter int STUCK_LIMIT = 64,
    parameter int CNT_W       = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [N_SENSORS-1:0] sensor_in,
    input  logic                 fault_clr,
    output logic                 alarm,
    output logic                 event_valid,
    output logic [N_SENSORS-1:0] flag,
    output logic [N_SENSORS-1:0] fault,
    output logic                 degraded,
    output logic [1:0]           state_o,
    output logic [CNT_W-1:0]     event_count
);
    localparam int HOLD_W = $clog2(HOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD - 1);

    if (!params_ok(N_SENSORS, VOTE_K, PERSIST, HOLD, STUCK_LIMIT, CNT_W)) begin : g_bad_params
        $error("trust_event_detector: illegal parameter combination");
    end

    logic [N_SENSORS-1:0] w_qualified;
    int                   w_votes;
    int                   w_faults;
    logic                 w_vote_met;

    state_t               r_state;
    logic [HOLD_W-1:0]    r_hold;
    logic                 r_event_valid;
    logic [N_SENSORS-1:0] r_flag;
    logic [CNT_W-1:0]     r_event_count;

    for (genvar i = 0; i < N_SENSORS; i++) begin : g_chan
        sensor_channel_filter #(
            .PERSIST     (PERSIST),
            .STUCK_LIMIT (STUCK_LIMIT)
        ) u_filter (
            .clk       (clk),
            .rst       (rst),
            .en        (en),
            .sensor    (sensor_in[i]),
            .vote_met  (w_vote_met),
            .fault_clr (fault_clr),
            .qualified (w_qualified[i]),
            .fault     (fault[i])
        );
    end

    assign w_votes    = int'(popcount(MAX_SENSORS'(w_qualified)));
    assign w_faults   = int'(popcount(MAX_SENSORS'(fault)));
    assign w_vote_met = (w_votes >= VOTE_K);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_hold        <= '0;
            r_event_valid <= 1'b0;
            r_flag        <= '0;
            r_event_count <= '0;
        end else if (!en) begin
            r_event_valid <= 1'b0;
        end else begin
            r_event_valid <= 1'b0;
            case (r_state)
                ST_IDLE, ST_SUSPECT: begin
                    if (w_vote_met) begin
                        r_state       <= ST_CONFIRM;
                        r_event_valid <= 1'b1;
                        r_flag        <= w_qualified;
                        if (r_event_count != '1) begin
                            r_event_count <= r_event_count + CNT_W'(1);
                        end
                    end else if (w_votes == 0) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_state <= ST_SUSPECT;
                    end
                end
                ST_CONFIRM: begin
                    if (!w_vote_met) begin
                        r_state <= ST_HOLD;
                        r_hold  <= HOLD_LOAD;
                    end
                end
                ST_HOLD: begin
                    // Re-confirmation inside the hold window is the same event.
                    if (w_vote_met) begin
                        r_state <= ST_CONFIRM;
                    end else if (r_hold == '0) begin
                        r_state <= (w_votes >= 1) ? ST_SUSPECT : ST_IDLE;
                    end else begin
                        r_hold <= r_hold - HOLD_W'(1);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // NOTE: the pulse is gated by en so a stall never stretches or replays an event.
    assign event_valid = r_event_valid && en;
    assign alarm       = (r_state == ST_CONFIRM) || (r_state == ST_HOLD);
    assign flag        = r_flag;
    assign state_o     = r_state;
    assign event_count = r_event_count;
    assign degraded    = (N_SENSORS - w_faults) < VOTE_K;

endmodule

// File: tb/tb_trust_event_detector.sv
// Scenario tasks plus a randomized run checked against a cycle-level
// behavioural model of the detector's rules.
module tb_trust_event_detector;

    localparam int N           = 3;
    localparam int K           = 2;
    localparam int PERSIST     = 4;
    localparam int HOLD        = 8;
    localparam int STUCK_LIMIT = 64;
    localparam int CNT_W       = 16;
    localparam int VW          = 2 + 2 * N + 1 + 2 + CNT_W;

    logic             clk;
    logic             rst;
    logic             en;
    logic [N-1:0]     sensor_in;
    logic             fault_clr;
    logic             alarm;
    logic             event_valid;
    logic [N-1:0]     flag;
    logic [N-1:0]     fault;
    logic             degraded;
    logic [1:0]       state_o;
    logic [CNT_W-1:0] event_count;

    int total = 0;
    int bad   = 0;

    // Behavioural model state.
    int           m_pcnt  [N];
    int           m_stuck [N];
    logic [N-1:0] m_fault;
    int           m_state;
    int           m_hold;
    logic [N-1:0] m_flag;
    int           m_count;
    bit           m_ev;

    trust_event_detector #(
        .N_SENSORS   (N),
        .VOTE_K      (K),
        .PERSIST     (PERSIST),
        .HOLD        (HOLD),
        .STUCK_LIMIT (STUCK_LIMIT),
        .CNT_W       (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .sensor_in   (sensor_in),
        .fault_clr   (fault_clr),
        .alarm       (alarm),
        .event_valid (event_valid),
        .flag        (flag),
        .fault       (fault),
        .degraded    (degraded),
        .state_o     (state_o),
        .event_count (event_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic model_step();
        logic [N-1:0] q;
        int votes;
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                m_pcnt[i]  = 0;
                m_stuck[i] = 0;
            end
            m_fault = '0;
            m_state = 0;
            m_hold  = 0;
            m_flag  = '0;
            m_count = 0;
            m_ev    = 0;
        end else if (!en) begin
            m_ev = 0;
        end else begin
            votes = 0;
            for (int i = 0; i < N; i++) begin
                q[i]  = (m_pcnt[i] == PERSIST) && !m_fault[i];
                votes += int'(q[i]);
            end
            for (int i = 0; i < N; i++) begin
                m_pcnt[i] = sensor_in[i] ? ((m_pcnt[i] < PERSIST) ? m_pcnt[i] + 1 : PERSIST) : 0;
                if (fault_clr) begin
                    m_stuck[i] = 0;
                    m_fault[i] = 1'b0;
                end else if (!sensor_in[i] || votes >= K) begin
                    m_stuck[i] = 0;
                end else if (q[i]) begin
                    if (m_stuck[i] == STUCK_LIMIT) m_fault[i] = 1'b1;
                    else m_stuck[i]++;
                end
            end
            m_ev = 0;
            case (m_state)
                0, 1: begin
                    if (votes >= K) begin
                        m_state = 2;
                        m_ev    = 1;
                        m_flag  = q;
                        if (m_count < (1 << CNT_W) - 1) m_count++;
                    end else begin
                        m_state = (votes == 0) ? 0 : 1;
                    end
                end
                2: if (votes < K) begin
                    m_state = 3;
                    m_hold  = HOLD - 1;
                end
                default: begin
                    if (votes >= K) m_state = 2;
                    else if (m_hold == 0) m_state = (votes >= 1) ? 1 : 0;
                    else m_hold--;
                end
            endcase
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic apply_reset();
        rst       = 1'b1;
        en        = 1'b1;
        fault_clr = 1'b0;
        sensor_in = '0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        total++;
        if (state_o !== 2'd0) begin
            bad++;
            $display("FAIL reset_state: got %0d want 0", state_o);
        end
        total++;
        if ({alarm, event_valid, flag, fault, degraded, event_count} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got alarm=%b ev=%b flag=%b fault=%b deg=%b cnt=%0d want all 0",
                     alarm, event_valid, flag, fault, degraded, event_count);
        end
    endtask

    task automatic test_full_event();
        int ev_cycle = -1;
        int n_ev     = 0;
        int fall     = -1;
        apply_reset();
        sensor_in = 3'b111;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (event_valid === 1'b1) begin
                n_ev++;
                if (ev_cycle < 0) ev_cycle = c;
            end
        end
        total++;
        if (ev_cycle != PERSIST + 1) begin
            bad++;
            $display("FAIL full_ev_cycle: got %0d want %0d", ev_cycle, PERSIST + 1);
        end
        total++;
        if (n_ev != 1) begin
            bad++;
            $display("FAIL full_ev_count: got %0d pulses want 1", n_ev);
        end
        total++;
        if (flag !== 3'b111 || event_count !== 16'd1 || alarm !== 1'b1) begin
            bad++;
            $display("FAIL full_confirm: got flag=%b cnt=%0d alarm=%b want 111/1/1", flag, event_count, alarm);
        end
        // Tick 1 samples the drop (votes fall there); alarm clears HOLD+1 edges later.
        sensor_in = '0;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (alarm === 1'b0 && fall < 0) fall = c;
        end
        total++;
        if (fall != HOLD + 2) begin
            bad++;
            $display("FAIL full_alarm_fall: got tick %0d want %0d", fall, HOLD + 2);
        end
        total++;
        if (state_o !== 2'd0) begin
            bad++;
            $display("FAIL full_end_idle: got %0d want 0", state_o);
        end
    endtask

    task automatic test_short_pulse();
        bit saw_ev  = 0;
        bit saw_bad = 0;
        apply_reset();
        sensor_in = 3'b011;
        for (int c = 0; c < 8; c++) begin
            if (c == PERSIST - 1) sensor_in = '0;
            tick();
            if (event_valid !== 1'b0) saw_ev = 1;
            if (state_o > 2'd1) saw_bad = 1;
        end
        total++;
        if (saw_ev || saw_bad || event_count !== 16'd0) begin
            bad++;
            $display("FAIL short_pulse: got ev=%0d confirm=%0d cnt=%0d want 0/0/0", saw_ev, saw_bad, event_count);
        end
    endtask

    task automatic test_stuck_fault();
        int  f_cycle;
        bit  saw_suspect;
        logic [N-1:0] pats [2] = '{3'b100, 3'b010};
        logic [N-1:0] want [2] = '{3'b100, 3'b110};
        apply_reset();
        for (int p = 0; p < 2; p++) begin
            f_cycle     = -1;
            saw_suspect = 0;
            sensor_in   = pats[p];
            for (int c = 1; c <= 80; c++) begin
                tick();
                if (state_o === 2'd1) saw_suspect = 1;
                if (fault === want[p] && f_cycle < 0) f_cycle = c;
            end
            total++;
            if (f_cycle != PERSIST + STUCK_LIMIT + 1 || !saw_suspect) begin
                bad++;
                $display("FAIL stuck_fault_%0d: got tick %0d suspect=%0d want tick %0d suspect=1",
                         p, f_cycle, saw_suspect, PERSIST + STUCK_LIMIT + 1);
            end
            total++;
            if (fault !== want[p] || state_o !== 2'd0 || degraded !== (p == 1)) begin
                bad++;
                $display("FAIL stuck_after_%0d: got fault=%b state=%0d deg=%b want %b/0/%0d",
                         p, fault, state_o, degraded, want[p], p);
            end
        end
        sensor_in = 3'b111;
        for (int c = 0; c < 20; c++) tick();
        total++;
        if (state_o !== 2'd1 || alarm !== 1'b0 || event_count !== 16'd0) begin
            bad++;
            $display("FAIL degraded_no_confirm: got state=%0d alarm=%b cnt=%0d want 1/0/0", state_o, alarm, event_count);
        end
        sensor_in = '0;
        fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0;
        total++;
        if (fault !== 3'b000 || degraded !== 1'b0) begin
            bad++;
            $display("FAIL fault_clear: got fault=%b deg=%b want 000/0", fault, degraded);
        end
    endtask

    task automatic test_clear_wins();
        apply_reset();
        sensor_in = 3'b100;
        for (int c = 1; c < PERSIST + STUCK_LIMIT + 1; c++) tick();
        fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0;
        total++;
        if (fault !== 3'b000) begin
            bad++;
            $display("FAIL clear_wins: got fault=%b want 000", fault);
        end
        for (int c = 0; c < STUCK_LIMIT; c++) tick();
        total++;
        if (fault !== 3'b000) begin
            bad++;
            $display("FAIL restart_early: got fault=%b want 000", fault);
        end
        tick();
        total++;
        if (fault !== 3'b100) begin
            bad++;
            $display("FAIL restart_limit: got fault=%b want 100", fault);
        end
    endtask

    task automatic test_back_to_back();
        bit saw_hold = 0;
        bit alarm_gap = 0;
        int n_ev = 0;
        apply_reset();
        sensor_in = 3'b011;
        for (int c = 0; c < 10; c++) tick();
        total++;
        if (flag !== 3'b011 || event_count !== 16'd1) begin
            bad++;
            $display("FAIL b2b_first: got flag=%b cnt=%0d want 011/1", flag, event_count);
        end
        sensor_in = '0;
        for (int c = 0; c < 15; c++) begin
            if (c == 3) sensor_in = 3'b011;
            tick();
            if (state_o === 2'd3) saw_hold = 1;
            if (alarm !== 1'b1) alarm_gap = 1;
            if (event_valid === 1'b1) n_ev++;
        end
        total++;
        if (!saw_hold || alarm_gap || n_ev != 0 || event_count !== 16'd1 || state_o !== 2'd2) begin
            bad++;
            $display("FAIL b2b_reraise: got hold=%0d gap=%0d pulses=%0d cnt=%0d state=%0d want 1/0/0/1/2",
                     saw_hold, alarm_gap, n_ev, event_count, state_o);
        end
    endtask

    task automatic test_reset_mid_event();
        apply_reset();
        sensor_in = 3'b111;
        for (int c = 0; c < 8; c++) tick();
        total++;
        if (state_o !== 2'd2) begin
            bad++;
            $display("FAIL mid_pre_state: got %0d want 2", state_o);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++;
        if ({alarm, event_valid, flag, fault, event_count, state_o} !== '0) begin
            bad++;
            $display("FAIL mid_reset: got alarm=%b ev=%b flag=%b fault=%b cnt=%0d state=%0d want all 0",
                     alarm, event_valid, flag, fault, event_count, state_o);
        end
    endtask

    task automatic test_enable_freeze();
        bit moved = 0;
        int ev_cycle = -1;
        apply_reset();
        sensor_in = 3'b111;
        tick();
        tick();
        en = 1'b0;
        for (int c = 0; c < 10; c++) begin
            sensor_in = N'($urandom);
            tick();
            if (event_valid !== 1'b0 || state_o !== 2'd0 || alarm !== 1'b0) moved = 1;
        end
        en = 1'b1;
        sensor_in = 3'b111;
        for (int c = 1; c <= 6; c++) begin
            tick();
            if (event_valid === 1'b1 && ev_cycle < 0) ev_cycle = c;
        end
        total++;
        if (moved || ev_cycle != PERSIST - 1) begin
            bad++;
            $display("FAIL enable_freeze: got moved=%0d ev tick %0d want 0/%0d", moved, ev_cycle, PERSIST - 1);
        end
    endtask

    task automatic test_random();
        logic [VW-1:0] got;
        logic [VW-1:0] exp;
        int seg = 0;
        apply_reset();
        for (int c = 0; c < 2500; c++) begin
            if (seg == 0) begin
                if ($urandom_range(0, 14) == 0) begin
                    sensor_in = N'(1 << $urandom_range(0, N - 1));
                    seg = $urandom_range(60, 90);
                end else begin
                    sensor_in = N'($urandom);
                    seg = $urandom_range(1, 12);
                end
            end
            seg--;
            rst       = ($urandom_range(0, 299) == 0);
            en        = ($urandom_range(0, 9) != 0);
            fault_clr = ($urandom_range(0, 79) == 0);
            tick();
            got = {alarm, event_valid, flag, fault, degraded, state_o, event_count};
            exp = {(m_state >= 2), (m_ev && en), m_flag, m_fault,
                   ((N - $countones(m_fault)) < K), 2'(m_state), CNT_W'(m_count)};
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL random_cycle_%0d: got %h want %h", c, got, exp);
            end
        end
        rst = 1'b0;
        en  = 1'b1;
        fault_clr = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        en        = 1'b1;
        fault_clr = 1'b0;
        sensor_in = '0;
        @(negedge clk);
        test_reset();
        test_full_event();
        test_short_pulse();
        test_stuck_fault();
        test_clear_wins();
        test_back_to_back();
        test_reset_mid_event();
        test_enable_freeze();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/trust_event_detector.md
Name: trust_event_detector

Overview:
Clocked, parametrised successor to the combinational three-sensor fire comparator. Each of N binary sensor channels is debounced by a persistence filter. A K-of-N vote confirms an event. Channels that stay asserted without corroboration are marked faulty and excluded from the vote. The block sits between the sensor front-end and the alarm/reporting logic, and outputs a held alarm, a one-cycle event pulse, per-channel agreement flags and per-channel fault flags.

Parameters:
N_SENSORS, 3, number of sensor channels (>=2).
VOTE_K, 2, qualified channels required to confirm an event (1..N_SENSORS). Any other value is a elaboration error.
PERSIST, 4, consecutive high samples before a channel is qualified (>=1).
HOLD, 8, cycles the alarm is held after the vote drops below VOTE_K (>=1).
STUCK_LIMIT, 64, cycles a channel may be qualified while the vote is below VOTE_K before it is marked faulty.
CNT_W, 16, width of the event counter.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  synchronous, active-high reset.
en  in  1  when low, all internal state and outputs hold; event_valid forced 0.
sensor_in  in  N_SENSORS  raw sensor levels, bit i = channel i.
fault_clr  in  1  one-cycle pulse; clears all fault bits and stuck counters.
alarm  out  1  high in CONFIRM and HOLD.
event_valid  out  1  one-cycle pulse on each new confirmed event.
flag  out  N_SENSORS  qualified vector latched at confirmation (trust map).
fault  out  N_SENSORS  sticky per-channel fault flags.
degraded  out  1  combinational: (N_SENSORS - popcount(fault)) < VOTE_K.
state_o  out  2  FSM state: IDLE=0, SUSPECT=1, CONFIRM=2, HOLD=3.
event_count  out  CNT_W  confirmed events, saturating at all-ones.

Behaviour:
- Reset: all counters 0, state IDLE, alarm=0, event_valid=0, flag=0, fault=0, event_count=0. A reset mid-event aborts the event with no pulse.
- Per-channel persistence counter (en=1):
  - sensor_in[i]=1: increment, saturating at PERSIST.
  - sensor_in[i]=0: clear to 0.
- qualified[i] = (pcnt[i]==PERSIST) && !fault[i]. votes = popcount(qualified).
- Stuck counter: increments while qualified[i] && votes<VOTE_K. Clears when sensor_in[i]=0 or votes>=VOTE_K. On reaching STUCK_LIMIT, fault[i] is set next edge and the counter stops.
  - fault_clr clears fault and all stuck counters. If fault_clr coincides with a stuck-limit hit, clear wins.
- FSM (registered, evaluated on each edge with en=1):
  - IDLE: votes>=VOTE_K -> CONFIRM; votes>=1 -> SUSPECT; else stay.
  - SUSPECT: votes>=VOTE_K -> CONFIRM; votes==0 -> IDLE; else stay.
  - CONFIRM: votes<VOTE_K -> HOLD (load hold counter with HOLD-1); else stay.
  - HOLD: votes>=VOTE_K -> CONFIRM with no new pulse and no count increment. Hold counter 0 -> SUSPECT if votes>=1, else IDLE. Otherwise decrement.
- Event pulse: event_valid=1 for exactly the cycle after entering CONFIRM from IDLE or SUSPECT. On that same edge flag<=qualified and event_count increments, saturating.
- Latency: K channels rising together before edge 1 and held give qualified=1 after edge PERSIST. event_valid and alarm go high after edge PERSIST+1. Alarm falls HOLD+1 edges after votes drop.
- degraded=1 makes confirmation impossible. The FSM still runs; alarm only persists through any current HOLD.

Decomposition:
- Package trust_event_pkg: state enum (IDLE/SUSPECT/CONFIRM/HOLD, 2 bits); popcount function; parameter-check constants.
- Sub-module sensor_channel_filter: instanced N_SENSORS times. Contains the persistence and stuck counters and the fault bit. Ports: clk, rst, en, sensor, vote_met, fault_clr, qualified, fault.
- Top level: vote, FSM, hold counter, flag/count registers.

Test Plan:
- Defaults, all three sensors 1 for 20 cycles then 0 -> event_valid pulse after edge 5, flag=3'b111, event_count=1, alarm high until 9 edges after the drop, then IDLE.
- Channels 0 and 1 high for 3 cycles only (PERSIST=4) -> state reaches SUSPECT at most, no event_valid, event_count=0.
- Only channel 2 high for 80 cycles -> SUSPECT, fault=3'b100 after stuck limit, then state IDLE; fault_clr -> fault=0.
- Channels 0 and 1 held high -> event with flag=3'b011. Drop both for 3 cycles, then re-raise during HOLD -> back to CONFIRM, no second pulse, event_count stays 1.
- rst asserted for one cycle while in CONFIRM -> the cycle after the edge shows all outputs 0, state IDLE.
- en=0 for 10 cycles mid-persistence -> counters frozen; on en=1 confirmation completes after the remaining samples.
